// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR on two WIDTH-bit operands,
// evaluated SLICE bits per clock between a valid/ready input and output handshake.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;

    function automatic logic [SLICE-1:0] slice_op(input op_e op,
                                                  input logic [SLICE-1:0] a,
                                                  input logic [SLICE-1:0] b);
        case (op)
            OP_AND:  slice_op = a & b;
            OP_OR:   slice_op = a | b;
            OP_XOR:  slice_op = a ^ b;
            default: slice_op = ~(a | b);
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    op_d    = op_e'(op_i);
                    a_d     = a_i;
                    b_d     = b_i;
                    s_d     = '0;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_d[idx_q*SLICE +: SLICE] = slice_op(op_q, a_q[idx_q*SLICE +: SLICE],
                                                     b_q[idx_q*SLICE +: SLICE]);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the reset is synchronous and clears operands as well.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are forced quiet for as long as reset is held low.
    assign in_ready_o  = rst_ni && (state_q == IDLE);
    assign out_valid_o = rst_ni && (state_q == DONE);
    assign s_o         = rst_ni ? s_q : '0;
    assign zero_o      = rst_ni && (s_q == '0);

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq: default, 16/16 and 64/8 instances.
module tb_logic_unit_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // default instance (WIDTH=32, SLICE=8)
    logic        iv, ir, ov, ordy, zr;
    logic [1:0]  op;
    logic [31:0] a, b, s;

    logic_unit_seq u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv), .in_ready_o(ir), .op_i(op),
        .a_i(a), .b_i(b), .out_valid_o(ov), .out_ready_i(ordy), .s_o(s), .zero_o(zr)
    );

    // WIDTH=16, SLICE=16 instance
    logic        iv16, ir16, ov16, zr16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, s16;

    logic_unit_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv16), .in_ready_o(ir16), .op_i(op16),
        .a_i(a16), .b_i(b16), .out_valid_o(ov16), .out_ready_i(1'b1), .s_o(s16), .zero_o(zr16)
    );

    // WIDTH=64, SLICE=8 instance
    logic        iv64, ir64, ov64, zr64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, s64;

    logic_unit_seq #(.WIDTH(64), .SLICE(8)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv64), .in_ready_o(ir64), .op_i(op64),
        .a_i(a64), .b_i(b64), .out_valid_o(ov64), .out_ready_i(1'b1), .s_o(s64), .zero_o(zr64)
    );

    // Called at the first negedge after the accepting edge; lat = edges since accept.
    task automatic wait_result(input bit scramble, output int lat);
        lat = 0;
        while (!ov && lat < 40) begin
            if (scramble) begin
                a  = $urandom;
                b  = $urandom;
                op = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_s, input logic exp_z, input int hold,
                         input bit scramble, input string tag);
        int          lat;
        logic [31:0] s_hold;
        bit          stable;
        @(negedge clk);
        op = o; a = av; b = bv; iv = 1'b1; ordy = (hold == 0);
        check({tag, "_in_ready"}, ir, 1);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        wait_result(scramble, lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_s"}, s, exp_s);
        check({tag, "_zero"}, zr, exp_z);
        if (hold > 0) begin
            s_hold = s;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!ov || s !== s_hold || zr !== exp_z || ir) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, stable, 1);
            ordy = 1'b1;
        end
        @(negedge clk);
        check({tag, "_back_idle"}, {ov, ir}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gap, lat;
        bit          seen, quiet;
        logic [31:0] xs;

        rst_n = 1'b0; iv = 1'b0; op = 2'b00; a = '0; b = '0; ordy = 1'b1;
        iv16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
        iv64 = 1'b0; op64 = 2'b00; a64 = '0; b64 = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", ir, 0);
        check("rst_out_valid", ov, 0);
        check("rst_s", s, 0);
        check("rst_zero", zr, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", ir, 1);

        // AND
        do_op(2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 0, 1'b0, "and");

        // XOR then NOR back-to-back with out_ready high
        @(negedge clk);
        ordy = 1'b1; op = 2'b10; a = 32'hAAAA_5555; b = 32'hFFFF_0000; iv = 1'b1;
        check("b2b_in_ready", ir, 1);
        @(posedge clk);
        @(negedge clk);
        op = 2'b11; a = 32'h0; b = 32'h0;
        gap = 0; seen = 1'b0; xs = '0;
        while (!ir && gap < 40) begin
            if (ov) begin seen = 1'b1; xs = s; end
            @(negedge clk);
            gap++;
        end
        check("b2b_xor_seen", seen, 1);
        check("b2b_xor_s", xs, 32'h5555_5555);
        check("b2b_issue_gap", gap + 1, 6);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        wait_result(1'b0, lat);
        check("b2b_nor_latency", lat, 4);
        check("b2b_nor_s", s, 32'hFFFF_FFFF);
        @(negedge clk);

        // zero flag with 10 cycles of backpressure
        do_op(2'b00, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 10, 1'b0, "bp");

        // operand isolation: inputs scrambled every BUSY cycle
        do_op(2'b01, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 0, 1'b1, "iso_or");
        do_op(2'b11, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 0, 1'b1, "iso_nor");

        // reset during the 2nd BUSY cycle
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h0; iv = 1'b1; ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", ov, 0);
        check("mid_rst_s", s, 0);
        check("mid_rst_in_ready", ir, 0);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ov || ir) quiet = 1'b0;
        end
        check("mid_rst_quiet", quiet, 1);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_s", s, 0);
        check("mid_rst_release_idle", {ov, ir}, 2'b01);
        do_op(2'b01, 32'h0000_00FF, 32'hFF00_0000, 32'hFF00_00FF, 1'b0, 0, 1'b0, "post_rst_or");

        // WIDTH=16, SLICE=16: single-cycle evaluation
        @(negedge clk);
        op16 = 2'b01; a16 = 16'h00F0; b16 = 16'h0F00; iv16 = 1'b1;
        check("w16_in_ready", ir16, 1);
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 40) begin @(negedge clk); lat++; end
        check("w16_latency", lat, 1);
        check("w16_s", s16, 16'h0FF0);
        check("w16_zero", zr16, 0);

        // WIDTH=64, SLICE=8: eight slices
        @(negedge clk);
        op64 = 2'b10; a64 = '1; b64 = '1; iv64 = 1'b1;
        check("w64_in_ready", ir64, 1);
        @(posedge clk);
        @(negedge clk);
        iv64 = 1'b0;
        lat = 0;
        while (!ov64 && lat < 40) begin @(negedge clk); lat++; end
        check("w64_latency", lat, 8);
        check("w64_s", s64, 64'h0);
        check("w64_zero", zr64, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the processor datapath. It evaluates AND, OR, XOR or NOR on two WIDTH-bit operands, SLICE bits per clock. Operands enter through a valid/ready handshake and the result leaves through a second valid/ready handshake with a zero flag. It sits beside the ALU as the shared logic-op engine and replaces the fixed 32-bit, single-function gate arrays.

## Interface
- WIDTH, 32, operand and result width in bits
- SLICE, 8, bits evaluated per cycle; WIDTH % SLICE != 0 is illegal and must fail elaboration
- Derived: N = WIDTH/SLICE slices; slice counter width = max(1, clog2(N))
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
- in_valid  input  1  A, B and op are presented
- in_ready  output  1  unit accepts an operation this cycle
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  S and zero hold a completed result
- out_ready  input  1  consumer takes the result this cycle
- S  output  WIDTH  result register
- zero  output  1  1 when S == 0; meaningful only while out_valid

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register A, B and op, clear S to 0 and idx to 0, then go to BUSY.
- BUSY:
  - in_ready = 0 and out_valid = 0.
  - Each cycle, write S[idx*SLICE +: SLICE] = f(op, A_reg slice, B_reg slice), then increment idx.
  - After the write with idx == N-1, go to DONE. idx never wraps past N-1.
- DONE:
  - out_valid = 1; S and zero are held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 during DONE. There is no accept in the same cycle as the result is taken.
- Operands are captured at accept. Changes on A, B or op after accept have no effect on the result.
- zero = ~|S, registered or combinational from S, valid whenever out_valid = 1.
- NOR = ~(A|B) per bit. No carries; slices are independent.
- Reset low, at any state, on the next edge:
  - state goes to IDLE; S, idx and the operand registers are cleared to 0.
  - An in-flight operation is discarded and never produces out_valid.
- While reset is low: in_ready = 0, out_valid = 0, S = 0, zero = 0.

## Timing
- Accept edge is E0. BUSY writes occur at edges E1..EN. out_valid is high from the cycle after EN.
- Latency: out_valid rises exactly N cycles after the accepting edge (N = 4 for default parameters).
- Minimum issue interval is N+2 cycles, when out_ready is held high: accept, N BUSY cycles, 1 DONE cycle, return to IDLE.
- out_valid is held for any number of cycles until out_ready. S must not change during that time.
- out_ready while not in DONE is ignored. in_valid while in_ready = 0 is ignored; the source must hold it.
- SLICE == WIDTH (N = 1): one BUSY cycle; out_valid rises 1 cycle after accept.
- First accept after reset deassertion: possible at the first edge where reset is high and in_valid = 1.

## Test plan
- AND, default parameters: A=32'hF0F0_1234, B=32'h0FF0_FFFF, op=00 -> S=32'h00F0_1234 and zero=0, with out_valid exactly 4 cycles after accept.
- XOR then NOR, back-to-back with out_ready held high:
  - XOR A=32'hAAAA_5555, B=32'hFFFF_0000 -> 32'h5555_5555.
  - NOR A=0, B=0 -> 32'hFFFF_FFFF.
  - The second accept occurs exactly 6 cycles after the first; in_ready = 0 in between.
- Zero flag and backpressure:
  - AND A=32'hFFFF_0000, B=32'h0000_FFFF -> S=0, zero=1.
  - Hold out_ready=0 for 10 cycles: out_valid, S and zero stay stable and in_ready stays 0.
  - Release out_ready: IDLE is re-entered on the next edge.
- Operand isolation: change A, B and op every cycle during BUSY -> result matches the values captured at accept.
- Reset mid-operation: drop reset during the 2nd BUSY cycle.
  - After the next edge: out_valid=0, S=0, in_ready=0 while reset is low.
  - After release, a new OR of A=32'h0000_00FF, B=32'hFF00_0000 -> 32'hFF00_00FF.
- Alternate parameters:
  - WIDTH=16, SLICE=16: OR of 16'h00F0 | 16'h0F00 -> 16'h0FF0 with 1-cycle latency.
  - WIDTH=64, SLICE=8: 8-cycle latency; XOR of all-ones against all-ones -> 0, zero=1.
